// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter that owns the select of a shared N:1 data mux and
// presents the winner's word downstream through a Valid/Ready handshake.
module mux_round_robin_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                                 Clock_In,
    input  logic                                 Reset_n_In,
    input  logic [NUM_REQUESTERS-1:0]            Request_In,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] Data_In,
    input  logic                                 Ready_In,
    output logic [NUM_REQUESTERS-1:0]            Grant_Out,
    output logic [$clog2(NUM_REQUESTERS)-1:0]    Select_Out,
    output logic                                 Valid_Out,
    output logic [DATA_WIDTH-1:0]                Data_Out,
    output logic [NUM_REQUESTERS-1:0]            Ack_Out
);

    localparam int SELECT_WIDTH = $clog2(NUM_REQUESTERS);
    localparam logic [SELECT_WIDTH:0]   N_W      = (SELECT_WIDTH+1)'(NUM_REQUESTERS);
    localparam logic [SELECT_WIDTH-1:0] LAST_IDX = SELECT_WIDTH'(NUM_REQUESTERS-1);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [SELECT_WIDTH-1:0]   r_ptr;
    logic [SELECT_WIDTH-1:0]   r_sel;
    logic [NUM_REQUESTERS-1:0] r_grant;
    logic [NUM_REQUESTERS-1:0] r_ack;
    logic [SELECT_WIDTH:0]     w_cand;
    logic [SELECT_WIDTH-1:0]   w_win_sel;
    logic                      w_found;
    logic [SELECT_WIDTH-1:0]   w_ptr_next;

    // Search upward from the pointer; the wrap is an explicit subtract so
    // non power-of-two requester counts behave.
    always_comb begin
        w_found   = 1'b0;
        w_win_sel = '0;
        w_cand    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            w_cand = {1'b0, r_ptr} + (SELECT_WIDTH+1)'(i);
            if (w_cand >= N_W) begin
                w_cand = w_cand - N_W;
            end
            if (!w_found && Request_In[w_cand[SELECT_WIDTH-1:0]]) begin
                w_found   = 1'b1;
                w_win_sel = w_cand[SELECT_WIDTH-1:0];
            end
        end
    end

    assign w_ptr_next = (r_sel == LAST_IDX) ? '0 : r_sel + SELECT_WIDTH'(1);

    // Handshake has priority over withdrawal when both happen on one edge.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next_state = GRANT;
            GRANT: begin
                if (Ready_In)                w_next_state = ACK;
                else if (!Request_In[r_sel]) w_next_state = IDLE;
            end
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_win_sel;
                        r_grant <= NUM_REQUESTERS'(1) << w_win_sel;
                    end
                end
                GRANT: begin
                    if (Ready_In) begin
                        r_ack   <= r_grant;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                    end else if (!Request_In[r_sel]) begin
                        r_grant <= '0;
                    end
                end
                ACK:     r_ack <= '0;
                default: begin
                    r_grant <= '0;
                    r_ack   <= '0;
                end
            endcase
        end
    end

    assign Grant_Out  = r_grant;
    assign Select_Out = r_sel;
    assign Valid_Out  = (r_state == GRANT);
    assign Ack_Out    = r_ack;
    assign Data_Out   = Valid_Out ? Data_In[r_sel*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_mux_round_robin_arbiter.sv
// Bench for mux_round_robin_arbiter: directed scenarios plus a random run,
// all checked against a transfer-level reference model.
module tb_mux_round_robin_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            Clock_In;
    logic            Reset_n_In;
    logic [N-1:0]    Request_In;
    logic [N*DW-1:0] Data_In;
    logic            Ready_In;
    logic [N-1:0]    Grant_Out;
    logic [1:0]      Select_Out;
    logic            Valid_Out;
    logic [DW-1:0]   Data_Out;
    logic [N-1:0]    Ack_Out;

    mux_round_robin_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) dut (
        .Clock_In   (Clock_In),
        .Reset_n_In (Reset_n_In),
        .Request_In (Request_In),
        .Data_In    (Data_In),
        .Ready_In   (Ready_In),
        .Grant_Out  (Grant_Out),
        .Select_Out (Select_Out),
        .Valid_Out  (Valid_Out),
        .Data_Out   (Data_Out),
        .Ack_Out    (Ack_Out)
    );

    initial Clock_In = 1'b0;
    always #5 Clock_In = ~Clock_In;

    int n_total = 0;
    int n_pass  = 0;

    // Model: 0 = no owner, 1 = owner presenting a word, 2 = owner being acked
    int m_phase;
    int m_ptr;
    int m_sel;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_sel   = 0;
    endtask

    task automatic model_edge();
        case (m_phase)
            0: if (Request_In != 0) begin m_sel = pick(Request_In, m_ptr); m_phase = 1; end
            1: begin
                if (Ready_In) begin m_ptr = (m_sel + 1) % N; m_phase = 2; end
                else if (!Request_In[m_sel]) m_phase = 0;
            end
            default: m_phase = 0;
        endcase
    endtask

    function automatic logic [18:0] exp_vec();
        logic [3:0] g, a;
        logic       v;
        logic [7:0] d;
        v = (m_phase == 1);
        g = v ? 4'(1 << m_sel) : 4'd0;
        a = (m_phase == 2) ? 4'(1 << m_sel) : 4'd0;
        d = v ? Data_In[m_sel*DW +: DW] : 8'd0;
        return {g, 2'(m_sel), v, d, a};
    endfunction

    task automatic step();
        model_edge();
        @(posedge Clock_In);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] obs, exp;
        Reset_n_In = 1'b0;
        Request_In = '0;
        Data_In    = '0;
        Ready_In   = 1'b0;
        model_reset();
        #12;
        obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
        n_total++;
        if (obs !== 19'd0) $display("FAIL reset_outputs got=%h want=0", obs);
        else n_pass++;
        @(negedge Clock_In);
        Reset_n_In = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
            exp = exp_vec();
            n_total++;
            if (obs !== exp || Valid_Out !== 1'b0 || Grant_Out !== 4'd0 || Ack_Out !== 4'd0)
                $display("FAIL idle_no_req c=%0d got=%h want=%h", c, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [18:0] obs, exp;
        logic [7:0]  want_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        logic [3:0]  want_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0]  got_d  [8];
        logic [3:0]  got_a  [8];
        int          rise_c [8];
        int          nd, na;
        logic        pv;
        nd = 0; na = 0; pv = 1'b0;
        Data_In    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        Request_In = 4'b1111;
        Ready_In   = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL rr_cycle c=%0d got=%h want=%h", c, obs, exp);
            else n_pass++;
            if (Valid_Out && !pv && nd < 8) begin got_d[nd] = Data_Out; rise_c[nd] = c; nd++; end
            if (Ack_Out != 0 && na < 8) begin got_a[na] = Ack_Out; na++; end
            pv = Valid_Out;
        end
        n_total++;
        if (nd < 5 || na < 5) $display("FAIL rr_count valids=%0d acks=%0d want>=5", nd, na);
        else begin
            n_pass++;
            for (int k = 0; k < 5; k++) begin
                n_total++;
                if (got_d[k] !== want_d[k] || got_a[k] !== want_a[k])
                    $display("FAIL rr_order k=%0d data=%h ack=%b want data=%h ack=%b",
                             k, got_d[k], got_a[k], want_d[k], want_a[k]);
                else n_pass++;
            end
            for (int k = 1; k < 5; k++) begin
                n_total++;
                if (rise_c[k] - rise_c[k-1] != 3)
                    $display("FAIL rr_spacing k=%0d got=%0d want=3", k, rise_c[k] - rise_c[k-1]);
                else n_pass++;
            end
        end
        Request_In = '0;
        step(); step();
    endtask

    task automatic test_wrap();
        logic [18:0] obs, exp;
        int sels [4];
        int ns;
        logic pv;
        ns = 0; pv = 1'b0;
        Ready_In = 1'b1;
        for (int c = 0; c < 9; c++) begin
            Request_In = (c < 3) ? 4'b1000 : 4'b1001;
            step();
            obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL wrap_cycle c=%0d got=%h want=%h", c, obs, exp);
            else n_pass++;
            if (Valid_Out && !pv && ns < 4) begin sels[ns] = int'(Select_Out); ns++; end
            pv = Valid_Out;
        end
        n_total++;
        if (ns != 3 || sels[0] != 3 || sels[1] != 0 || sels[2] != 3)
            $display("FAIL wrap_order n=%0d got=%0d,%0d,%0d want=3,0,3", ns, sels[0], sels[1], sels[2]);
        else n_pass++;
        Request_In = '0;
        step();
    endtask

    task automatic test_hold();
        logic [18:0] obs, exp;
        int nv, nack;
        nv = 0; nack = 0;
        Request_In = 4'b0100;
        Ready_In   = 1'b0;
        Data_In    = {8'h13, 8'h50, 8'h11, 8'h10};
        step();
        if (Valid_Out) nv++;
        for (int k = 0; k < 5; k++) begin
            Data_In[2*DW +: DW] = 8'(8'h60 + k);
            if (k == 2) Request_In = 4'b0110;
            step();
            obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
            exp = exp_vec();
            n_total++;
            if (obs !== exp || Data_Out !== 8'(8'h60 + k) || Grant_Out !== 4'b0100)
                $display("FAIL hold_cycle k=%0d got=%h want=%h", k, obs, exp);
            else n_pass++;
            if (Valid_Out) nv++;
        end
        Ready_In = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 0) Request_In = '0;
            obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL hold_tail c=%0d got=%h want=%h", c, obs, exp);
            else n_pass++;
            if (Ack_Out == 4'b0100) nack++;
            if (Valid_Out) nv++;
        end
        n_total++;
        if (nv != 6 || nack != 1) $display("FAIL hold_summary valid=%0d ack=%0d want 6,1", nv, nack);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        logic [18:0] obs, exp;
        Ready_In   = 1'b1;
        Request_In = 4'b0001;
        step(); step(); step();
        Request_In = 4'b0000;
        Ready_In   = 1'b0;
        Request_In = 4'b0010;
        step();
        n_total++;
        if (Valid_Out !== 1'b1 || Select_Out !== 2'd1)
            $display("FAIL wd_grant valid=%b sel=%0d want 1,1", Valid_Out, Select_Out);
        else n_pass++;
        Request_In = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
            exp = exp_vec();
            n_total++;
            if (obs !== exp || Valid_Out !== 1'b0 || Ack_Out !== 4'd0)
                $display("FAIL wd_abort c=%0d got=%h want=%h", c, obs, exp);
            else n_pass++;
        end
        Request_In = 4'b1110;
        step();
        n_total++;
        if (Valid_Out !== 1'b1 || Select_Out !== 2'd1 || Grant_Out !== 4'b0010)
            $display("FAIL wd_regrant valid=%b sel=%0d grant=%b want 1,1,0010", Valid_Out, Select_Out, Grant_Out);
        else n_pass++;
        Ready_In = 1'b1;
        step();
        Request_In = '0;
        step();
    endtask

    task automatic test_async_reset();
        logic [18:0] obs;
        Request_In = 4'b0100;
        Ready_In   = 1'b0;
        step();
        n_total++;
        if (Valid_Out !== 1'b1) $display("FAIL ar_pre valid=%b want 1", Valid_Out);
        else n_pass++;
        #3;
        Reset_n_In = 1'b0;
        model_reset();
        #1;
        obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
        n_total++;
        if (obs !== 19'd0) $display("FAIL ar_outputs got=%h want=0", obs);
        else n_pass++;
        #2;
        Reset_n_In = 1'b1;
        Request_In = 4'b1111;
        Ready_In   = 1'b1;
        step();
        n_total++;
        if (Grant_Out !== 4'b0001 || Select_Out !== 2'd0 || obs !== 19'd0 ||
            {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out} !== exp_vec())
            $display("FAIL ar_first_grant grant=%b sel=%0d want 0001,0", Grant_Out, Select_Out);
        else n_pass++;
        Request_In = '0;
        step(); step();
    endtask

    task automatic test_random();
        logic [18:0] obs, exp;
        int bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            Request_In = 4'($urandom_range(0, 15));
            Ready_In   = ($urandom_range(0, 3) != 0);
            Data_In    = $urandom;
            step();
            obs = {Grant_Out, Select_Out, Valid_Out, Data_Out, Ack_Out};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) begin
                bad++;
                if (bad <= 10) $display("FAIL random c=%0d got=%h want=%h", c, obs, exp);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_hold();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
